// File: rtl/adc_emulator_pkg.sv
// Shared types and command constants for the quad-lane SAR ADC emulator and its adc_manager peer.
package adc_emulator_pkg;

  typedef enum logic [1:0] {
    One  = 2'b00,
    Two  = 2'b01,
    Four = 2'b10
  } lane_mode_t;

  typedef enum logic {
    Conversion = 1'b0,
    RegAccess  = 1'b1
  } dev_mode_t;

  localparam logic [14:0] REG_MODE_ADDR    = 15'h0020;
  localparam logic [14:0] REG_EXIT_ADDR    = 15'h0014;
  localparam logic [2:0]  REG_ENTER_PREFIX = 3'b101;

  // Map a raw lane field to a mode the instantiated lane count can carry; 2'b11 reads as One.
  function automatic lane_mode_t clamp_lane(input logic [1:0] md, input int num_sdo);
    lane_mode_t m;
    case (md)
      2'b01:   m = Two;
      2'b10:   m = Four;
      default: m = One;
    endcase
    if (m == Four && num_sdo < 4) begin
      if (num_sdo >= 2) m = Two;
      else              m = One;
    end
    if (m == Two && num_sdo < 2) m = One;
    return m;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchroniser plus one registered stage giving single-cycle rise/fall pulses.
// Level out is 2 cycles after the input edge; pulses follow in the same cycle as the level change.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sr_q;
  logic [2:0] sr_d;

  assign sr_d = {sr_q[1:0], d_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sr_q <= {3{RST_VAL}};
    else         sr_q <= sr_d;
  end

  assign lvl_o  = sr_q[1];
  assign rise_o = sr_q[1] & ~sr_q[2];
  assign fall_o = ~sr_q[1] & sr_q[2];

endmodule

// File: rtl/adc_emulator.sv
// SPI responder emulating the quad-lane SAR ADC: cnv/busy conversion, lane-configurable readout, register commands.
// All SPI/cnv inputs oversampled in aclk; s_axis_tready pulses once per conversion only when a sample is offered.
module adc_emulator
  import adc_emulator_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          NUM_SDO      = 4,
  parameter int          CNV_CYCLES   = 14,
  parameter logic [31:0] TEST_PATTERN = 32'h8BADF00D
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cnv,
  output logic                  busy,
  input  logic                  spi_clk,
  input  logic                  spi_csn,
  input  logic                  spi_resetn,
  input  logic                  spi_sdi,
  output logic [NUM_SDO-1:0]    spi_sdo,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [31:0]           status
);

  localparam int CW = $clog2(CNV_CYCLES + 1);
  localparam int BW = $clog2(DATA_WIDTH + 5);

  logic cnv_lvl, cnv_rise, cnv_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic csn_lvl, csn_rise, csn_fall;
  logic rstn_lvl, rstn_rise, rstn_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;

  sync_edge #(.RST_VAL(1'b0)) u_sync_cnv (.clk_i(aclk), .rst_ni(aresetn), .d_i(cnv),
    .lvl_o(cnv_lvl), .rise_o(cnv_rise), .fall_o(cnv_fall));
  sync_edge #(.RST_VAL(1'b0)) u_sync_sck (.clk_i(aclk), .rst_ni(aresetn), .d_i(spi_clk),
    .lvl_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall));
  sync_edge #(.RST_VAL(1'b1)) u_sync_csn (.clk_i(aclk), .rst_ni(aresetn), .d_i(spi_csn),
    .lvl_o(csn_lvl), .rise_o(csn_rise), .fall_o(csn_fall));
  sync_edge #(.RST_VAL(1'b1)) u_sync_rst (.clk_i(aclk), .rst_ni(aresetn), .d_i(spi_resetn),
    .lvl_o(rstn_lvl), .rise_o(rstn_rise), .fall_o(rstn_fall));
  sync_edge #(.RST_VAL(1'b0)) u_sync_sdi (.clk_i(aclk), .rst_ni(aresetn), .d_i(spi_sdi),
    .lvl_o(sdi_lvl), .rise_o(sdi_rise), .fall_o(sdi_fall));

  logic unused_sync;
  assign unused_sync = ^{cnv_lvl, cnv_fall, sck_lvl, sck_fall, rstn_rise, rstn_fall, sdi_rise, sdi_fall};

  logic                  busy_q, busy_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  taken_q, taken_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [15:0]           overrun_q, overrun_d;
  logic                  rdy_q, rdy_d;
  dev_mode_t             mode_q, mode_d;
  lane_mode_t            lane_q, lane_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  reading_q, reading_d;
  logic [BW-1:0]         bits_q, bits_d;
  logic [23:0]           cmd_q, cmd_d;
  logic                  tready;
  logic                  conv_done;
  logic [2:0]            lanes_n;
  logic [3:0]            sdo_all;

  assign lanes_n = (lane_q == Four) ? 3'd4 : ((lane_q == Two) ? 3'd2 : 3'd1);

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    taken_d   = taken_q;
    hold_d    = hold_q;
    overrun_d = overrun_q;
    rdy_d     = rdy_q;
    mode_d    = mode_q;
    lane_d    = lane_q;
    shift_d   = shift_q;
    reading_d = reading_q;
    bits_d    = bits_q;
    cmd_d     = cmd_q;
    tready    = 1'b0;
    conv_done = 1'b0;

    // The sample is captured once, in the first busy cycle, so a read started alongside cnv sees the old value.
    if (busy_q) begin
      if (!taken_q) begin
        taken_d = 1'b1;
        if (s_axis_tvalid) begin
          tready = 1'b1;
          hold_d = s_axis_tdata;
        end else begin
          hold_d = DATA_WIDTH'(TEST_PATTERN);
        end
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d    = 1'b0;
        conv_done = 1'b1;
      end
    end

    if (cnv_rise) begin
      if (busy_q) begin
        if (overrun_q != 16'hFFFF) overrun_d = overrun_q + 16'd1;
      end else begin
        busy_d  = 1'b1;
        cnt_d   = CW'(CNV_CYCLES);
        taken_d = 1'b0;
      end
    end

    if (csn_fall) begin
      cmd_d = '0;
      if (mode_q == Conversion && rdy_q) begin
        shift_d   = hold_q;
        reading_d = 1'b1;
        bits_d    = BW'(lanes_n);
      end else begin
        shift_d   = '0;
        reading_d = 1'b0;
      end
    end else if (csn_rise) begin
      if (reading_q) rdy_d = 1'b0;
      reading_d = 1'b0;
      shift_d   = '0;
      if (cmd_q[23:21] == REG_ENTER_PREFIX) begin
        mode_d = RegAccess;
      end else if (mode_q == RegAccess && cmd_q[23:8] == {1'b0, REG_MODE_ADDR}) begin
        lane_d = clamp_lane(cmd_q[7:6], NUM_SDO);
      end else if (mode_q == RegAccess && cmd_q[23:8] == {1'b0, REG_EXIT_ADDR} && cmd_q[0]) begin
        mode_d = Conversion;
      end
    end else if (sck_rise && !csn_lvl) begin
      cmd_d   = {cmd_q[22:0], sdi_lvl};
      shift_d = shift_q << lanes_n;
      if (reading_q) begin
        bits_d = bits_q + BW'(lanes_n);
        if (bits_d >= BW'(DATA_WIDTH)) begin
          reading_d = 1'b0;
          rdy_d     = 1'b0;
        end
      end
    end

    if (conv_done) rdy_d = 1'b1;

    // Master-driven device reset: everything but the overrun history returns to power-on state.
    if (!rstn_lvl) begin
      busy_d    = 1'b0;
      cnt_d     = '0;
      taken_d   = 1'b0;
      hold_d    = '0;
      overrun_d = overrun_q;
      rdy_d     = 1'b0;
      mode_d    = Conversion;
      lane_d    = One;
      shift_d   = '0;
      reading_d = 1'b0;
      bits_d    = '0;
      cmd_d     = '0;
      tready    = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      taken_q   <= 1'b0;
      hold_q    <= '0;
      overrun_q <= '0;
      rdy_q     <= 1'b0;
      mode_q    <= Conversion;
      lane_q    <= One;
      shift_q   <= '0;
      reading_q <= 1'b0;
      bits_q    <= '0;
      cmd_q     <= '0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      taken_q   <= taken_d;
      hold_q    <= hold_d;
      overrun_q <= overrun_d;
      rdy_q     <= rdy_d;
      mode_q    <= mode_d;
      lane_q    <= lane_d;
      shift_q   <= shift_d;
      reading_q <= reading_d;
      bits_q    <= bits_d;
      cmd_q     <= cmd_d;
    end
  end

  always_comb begin
    sdo_all = '0;
    if (mode_q == Conversion) begin
      case (lane_q)
        One:     sdo_all[0]   = shift_q[DATA_WIDTH-1];
        Two:     sdo_all[1:0] = shift_q[DATA_WIDTH-1 -: 2];
        Four:    sdo_all      = shift_q[DATA_WIDTH-1 -: 4];
        default: sdo_all      = '0;
      endcase
    end
  end

  assign spi_sdo       = sdo_all[NUM_SDO-1:0];
  assign busy          = busy_q;
  assign s_axis_tready = tready;
  assign status        = {overrun_q, 11'b0, lane_q, (mode_q == RegAccess), rdy_q, busy_q};

endmodule

// File: tb/tb_adc_emulator.sv
// Directed bench for adc_emulator: conversion timing, lane readout, register commands, overrun and resets.
module tb_adc_emulator;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cnv = 1'b0;
  logic        busy;
  logic        spi_clk = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_resetn = 1'b1;
  logic        spi_sdi = 1'b0;
  logic [3:0]  spi_sdo;
  logic [31:0] s_axis_tdata = 32'h0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] status;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  adc_emulator dut (
    .aclk(aclk), .aresetn(aresetn), .cnv(cnv), .busy(busy),
    .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_resetn(spi_resetn), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .status(status)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic sck_pulse();
    spi_clk = 1'b1;
    tick(6);
    spi_clk = 1'b0;
    tick(6);
  endtask

  task automatic spi_cmd(input logic [23:0] c);
    spi_csn = 1'b0;
    tick(6);
    for (int i = 23; i >= 0; i--) begin
      spi_sdi = c[i];
      tick(2);
      sck_pulse();
    end
    spi_sdi = 1'b0;
    spi_csn = 1'b1;
    tick(6);
  endtask

  task automatic run_cnv(input logic dbl, output int nbusy, output int nrdy);
    nbusy = 0;
    nrdy  = 0;
    cnv   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (busy) nbusy++;
      if (s_axis_tready) nrdy++;
      if (i == 1) cnv = 1'b0;
      if (dbl && i == 3) cnv = 1'b1;
      if (i == 5) cnv = 1'b0;
    end
  endtask

  // Leaves csn low; the caller decides when the transfer ends.
  task automatic read_nibbles(input int n, output logic [31:0] w, output logic [3:0] acc);
    spi_csn = 1'b0;
    tick(6);
    w   = '0;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      w   = {w[27:0], spi_sdo};
      acc = acc | spi_sdo;
      sck_pulse();
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [3:0]  acc;
    int          nb, nr;

    tick(3);
    chk_eq("rst_status", status, 32'h0);
    chk_eq("rst_busy", {31'b0, busy}, 32'h0);
    chk_eq("rst_sdo", {28'b0, spi_sdo}, 32'h0);
    chk_eq("rst_tready", {31'b0, s_axis_tready}, 32'h0);
    aresetn = 1'b1;
    tick(4);

    // Empty stream, lane One: test pattern serialised MSB first on sdo[0].
    run_cnv(1'b0, nb, nr);
    chk_eq("t1_busy_cycles", nb, 32'd14);
    chk_eq("t1_tready_pulses", nr, 32'd0);
    chk_eq("t1_status_ready", status, 32'h0000_0002);
    spi_csn = 1'b0;
    tick(6);
    w   = '0;
    acc = '0;
    for (int k = 0; k < 32; k++) begin
      w   = {w[30:0], spi_sdo[0]};
      acc = acc | {spi_sdo[3:1], 1'b0};
      sck_pulse();
    end
    chk_eq("t1_word", w, 32'h8BADF00D);
    chk_eq("t1_unused_lanes", {28'b0, acc}, 32'h0);
    chk_eq("t1_tail_sdo", {28'b0, spi_sdo}, 32'h0);
    chk_eq("t1_status_drained", status, 32'h0);
    spi_csn = 1'b1;
    tick(6);

    // Lane command outside RegAccess is ignored; then enter, set Four, exit.
    spi_cmd(24'h002040);
    chk_eq("t2_ignored_cmd", status, 32'h0);
    spi_cmd(24'hA00000);
    chk_eq("t2_enter_reg", status, 32'h0000_0004);
    spi_cmd(24'h002080);
    chk_eq("t2_lane_four", status, 32'h0000_0014);
    spi_cmd(24'h001401);
    chk_eq("t2_exit_reg", status, 32'h0000_0010);
    s_axis_tdata  = 32'h0023FF42;
    s_axis_tvalid = 1'b1;
    run_cnv(1'b0, nb, nr);
    s_axis_tvalid = 1'b0;
    chk_eq("t2_busy_cycles", nb, 32'd14);
    chk_eq("t2_tready_pulses", nr, 32'd1);
    chk_eq("t2_status_ready", status, 32'h0000_0012);
    read_nibbles(8, w, acc);
    chk_eq("t2_word_four_lanes", w, 32'h0023FF42);
    chk_eq("t2_status_drained", status, 32'h0000_0010);
    spi_csn = 1'b1;
    tick(6);

    // Second cnv rise while busy: one conversion, one overrun.
    run_cnv(1'b1, nb, nr);
    chk_eq("t3_busy_cycles", nb, 32'd14);
    chk_eq("t3_status_overrun", status, 32'h0001_0012);

    // Abandon mid-word, then a read with no new conversion drives 0.
    spi_csn = 1'b0;
    tick(6);
    chk_eq("t4_first_nibble", {28'b0, spi_sdo}, 32'h8);
    sck_pulse();
    sck_pulse();
    sck_pulse();
    chk_eq("t4_fourth_nibble", {28'b0, spi_sdo}, 32'hD);
    chk_eq("t4_ready_mid_word", status, 32'h0001_0012);
    spi_csn = 1'b1;
    tick(6);
    chk_eq("t4_ready_abandoned", status, 32'h0001_0010);
    spi_csn = 1'b0;
    tick(6);
    chk_eq("t4_empty_read_sdo", {28'b0, spi_sdo}, 32'h0);
    sck_pulse();
    chk_eq("t4_empty_read_sdo2", {28'b0, spi_sdo}, 32'h0);
    spi_csn = 1'b1;
    tick(6);

    // RegAccess: lane 2'b11 maps to One, conversions run but reads stay silent.
    spi_cmd(24'hA00000);
    chk_eq("t5_enter_reg", status, 32'h0001_0014);
    spi_cmd(24'h0020C0);
    chk_eq("t5_lane_11_is_one", status, 32'h0001_0004);
    spi_cmd(24'h002080);
    chk_eq("t5_lane_four", status, 32'h0001_0014);
    s_axis_tdata  = 32'h12345678;
    s_axis_tvalid = 1'b1;
    run_cnv(1'b0, nb, nr);
    s_axis_tvalid = 1'b0;
    chk_eq("t5_busy_in_reg", nb, 32'd14);
    chk_eq("t5_status_ready", status, 32'h0001_0016);
    read_nibbles(8, w, acc);
    acc = acc | spi_sdo;
    chk_eq("t5_sdo_silent", {28'b0, acc}, 32'h0);
    spi_csn = 1'b1;
    tick(6);
    chk_eq("t5_ready_kept", status, 32'h0001_0016);
    spi_cmd(24'h001401);
    chk_eq("t5_exit_reg", status, 32'h0001_0012);
    s_axis_tdata  = 32'hCAFE0001;
    s_axis_tvalid = 1'b1;
    run_cnv(1'b0, nb, nr);
    s_axis_tvalid = 1'b0;
    read_nibbles(8, w, acc);
    chk_eq("t5_word_after_exit", w, 32'hCAFE0001);
    spi_csn = 1'b1;
    tick(6);

    // spi_resetn mid-read keeps only the overrun count.
    run_cnv(1'b0, nb, nr);
    spi_csn = 1'b0;
    tick(6);
    sck_pulse();
    sck_pulse();
    chk_eq("t6_third_nibble", {28'b0, spi_sdo}, 32'hA);
    spi_resetn = 1'b0;
    tick(6);
    chk_eq("t6_soft_rst_sdo", {28'b0, spi_sdo}, 32'h0);
    chk_eq("t6_soft_rst_status", status, 32'h0001_0000);
    spi_resetn = 1'b1;
    spi_csn    = 1'b1;
    tick(6);

    // aresetn mid-busy clears busy asynchronously.
    cnv = 1'b1;
    tick(2);
    cnv = 1'b0;
    tick(4);
    chk_eq("t7_busy_before", {31'b0, busy}, 32'h1);
    aresetn = 1'b0;
    #1;
    chk_eq("t7_busy_async_clear", {31'b0, busy}, 32'h0);
    chk_eq("t7_status_cleared", status, 32'h0);
    tick(2);
    aresetn = 1'b1;
    tick(4);
    chk_eq("t7_status_after", status, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_emulator.md
Name: adc_emulator

Overview:
- Synthesizable SPI responder that emulates the quad-lane SAR ADC that adc_manager drives.
- Used for on-board loopback and bring-up: adc_manager talks to it over cnv/busy/SPI exactly as it does to the real device.
- Sample values come from an AXI-Stream source, or from a fixed pattern when the stream is empty.
- All SPI/cnv inputs are oversampled in aclk; no logic is clocked by spi_clk.

Parameters:
- DATA_WIDTH, 32, bits per conversion result.
- NUM_SDO, 4, SDO lanes (1, 2 or 4).
- CNV_CYCLES, 14, aclk cycles busy stays high after a detected cnv rise.
- TEST_PATTERN, 32'h8BADF00D, result used when no AXIS sample is available.

Ports:
- aclk  in  1  system clock.
- aresetn  in  1  asynchronous active-low reset.
- cnv  in  1  conversion start, async.
- busy  out  1  conversion in progress.
- spi_clk  in  1  SPI clock from master, async, at most aclk/8.
- spi_csn  in  1  chip select, active low, async.
- spi_resetn  in  1  device reset from master, async, active low.
- spi_sdi  in  1  MOSI.
- spi_sdo  out  NUM_SDO  MISO lanes.
- s_axis_tdata  in  DATA_WIDTH  next sample value.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  sample accepted.
- status  out  32  {16'overrun_cnt, 11'b0, lane_md[1:0], reg_mode, data_ready, busy}.

Behaviour:
- Input synchronisation:
  - cnv, spi_clk, spi_csn, spi_resetn and spi_sdi each pass through a 2-FF synchroniser.
  - Edge detect is one registered stage after the synchroniser.
  - All events below refer to the synchronised edges.
- Reset:
  - aresetn low forces busy=0, spi_sdo=0, s_axis_tready=0, status=0.
  - It also sets device mode=Conversion, lane_md=One, data_ready=0, overrun_cnt=0 and holding register=0.
  - Synchronised spi_resetn low does the same, except overrun_cnt is kept.
- Conversion:
  - On a cnv rise with busy=0: busy=1 on the next cycle, and a counter loads CNV_CYCLES.
  - While busy: if s_axis_tvalid=1, pulse s_axis_tready for exactly 1 cycle and latch tdata into the holding register. Otherwise latch TEST_PATTERN.
  - When the counter reaches 0: busy=0 and data_ready=1.
  - A cnv rise while busy=1 is ignored and increments overrun_cnt, saturating at 16'hFFFF.
  - A new conversion overwrites the holding register. It does not disturb a read already in progress.
- Read (device mode Conversion):
  - csn fall with data_ready=1: load the shift register from the holding register, and drive the first lane group within 1 cycle.
  - Each subsequent spi_clk rise shifts by the lane count, MSB first: One=1 bit on sdo[0]; Two=2 bits on sdo[1:0]; Four=4 bits on sdo[3:0].
  - Lanes unused by the current mode drive 0.
  - The master samples on the next rising edge.
  - After DATA_WIDTH bits have been presented, data_ready=0; further shifts output 0.
  - csn fall with data_ready=0 drives 0.
  - A csn rise mid-word abandons the remaining bits and clears data_ready.
- Register command:
  - A 24-bit shift register shifts spi_sdi in on every spi_clk rise while csn is low. It clears on csn fall.
  - Decode happens on csn rise:
    - cmd[23:21]==3'b101 sets mode=RegAccess.
    - Else, if in RegAccess and cmd[23:8]=={1'b0,15'h0020}, set lane_md=cmd[7:6]. Value 2'b11 is treated as One.
    - Else, if in RegAccess and cmd[23:8]=={1'b0,15'h0014} and cmd[0]=1, set mode=Conversion.
    - All other commands are ignored.
  - While in RegAccess, spi_sdo=0 and reads are inhibited. Conversions still run.
- Lane limit: a lane_md requiring more lanes than NUM_SDO is clamped to the widest lane mode NUM_SDO supports.
- Simultaneous cnv rise and csn fall: the read uses the old holding value.

Decomposition:
- Package adc_emulator_pkg:
  - lane_mode_t enum: One=2'b00, Two=2'b01, Four=2'b10.
  - dev_mode_t enum: Conversion, RegAccess.
  - Constants: REG_MODE_ADDR=15'h0020, REG_EXIT_ADDR=15'h0014, REG_ENTER_PREFIX=3'b101.
  - Shared with adc_manager.
- Sub-module sync_edge: 2-FF synchroniser plus registered rise/fall pulses, parameterised reset value (csn resets to 1). Instantiate once per input.

Test Plan:
- Reset then cnv pulse with AXIS empty, lane One, 32 sck -> busy high for 14 cycles; sdo[0] serialises 8BADF00D MSB first.
- Send 24'hA00000, 24'h002080, 24'h001401, then cnv with s_axis_tdata=32'h0023FF42 valid -> tready pulses once; 8 sck on four lanes yield nibbles 0,0,2,3,F,F,4,2; status lane_md=2'b10.
- Two cnv rises 4 cycles apart -> only one conversion runs; overrun_cnt=1.
- csn raised after 3 sck in lane Four -> data_ready=0; next csn fall without cnv drives 0.
- Enter RegAccess, cnv and read -> sdo stays 0. After the exit command, the next cnv plus read returns the sample.
- spi_resetn low mid-read -> sdo=0, lane_md=One, mode=Conversion; aresetn low mid-busy -> busy=0 immediately.
